// File: rtl/addr_step_pkg.sv
// Shared types and defaults for the constant-step address generator.
package addr_step_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int STEP_DEF  = 2;

  typedef logic [WIDTH_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addr_step_gen_step_add.sv
// Combinational constant-step adder: sum = a + STEP, carry is the bit-WIDTH result.
module step_add #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // Zero-extend by one bit so the top bit of the result is the carry-out.
  assign {carry_o, sum_o} = {1'b0, a_i} + STEP_EXT;

endmodule

// File: rtl/addr_step_gen.sv
// Burst address generator: emits count_i values from base_i stepping by STEP,
// over a valid/ready handshake. All outputs are driven straight from flops.
module addr_step_gen
  import addr_step_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] addr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic             carry;

  step_add #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step_add (
    .a_i     (addr_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Next-state and datapath update; output flags are decoded from the next
  // state so they land in registers together with the state itself.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    accept  = valid_q & out_ready_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          wrap_d = 1'b0;
          if (count_i != '0) begin
            addr_d  = base_i;
            rem_d   = count_i;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          addr_d = sum;
          rem_d  = rem_q - 1'b1;
          if (carry) wrap_d = 1'b1;
          // Last beat: addr still advances but is no longer presented as valid.
          if (rem_q == WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid_o = valid_q;
  assign addr_o      = addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_addr_step_gen.sv
// Self-checking bench: each burst's expected beat list and wrap history are
// computed up front from base/count/STEP arithmetic and compared per cycle.
module tb_addr_step_gen;

  localparam int W = 8;
  localparam int S = 2;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] base_i;
  logic [W-1:0] count_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] addr_o;
  logic         busy_o;
  logic         done_o;
  logic         wrap_o;

  int errors = 0;
  int checks = 0;

  addr_step_gen #(.WIDTH(W), .STEP(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_i      (base_i),
    .count_i     (count_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .addr_o      (addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 random ready, 2 hold ready low 3 cycles on beat index 1.
  task automatic run_burst(input int base, input int count, input int ready_mode,
                           input bit poke_start);
    int exp_addr[$];
    bit carry_after[$];   // carry_after[k] = wrap expected after k accepts
    int idx;
    int stall;
    int cyc;
    bit rdy;
    exp_addr.delete();
    carry_after.delete();
    carry_after.push_back(1'b0);
    for (int i = 0; i < count; i++) begin
      exp_addr.push_back((base + i * S) % MOD);
      carry_after.push_back(carry_after[i] | ((((base + i * S) % MOD) + S) >= MOD));
    end

    start_i = 1'b1;
    base_i  = W'(base);
    count_i = W'(count);
    step();
    start_i = 1'b0;

    if (count == 0) begin
      chk("empty_done", done_o, 1);
      chk("empty_valid", out_valid_o, 0);
      chk("empty_wrap", wrap_o, 0);
      step();
      chk("empty_done_low", done_o, 0);
      chk("empty_busy_low", busy_o, 0);
      chk("empty_valid_low", out_valid_o, 0);
      return;
    end

    idx = 0;
    stall = 0;
    cyc = 0;
    while (idx < count) begin
      chk("run_valid", out_valid_o, 1);
      chk("run_busy", busy_o, 1);
      chk("run_done", done_o, 0);
      chk("run_addr", addr_o, exp_addr[idx]);
      chk("run_wrap", wrap_o, carry_after[idx]);
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (idx == 1 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      out_ready_i = rdy;
      if (poke_start) begin
        start_i = 1'b1;
        base_i  = W'($urandom);
        count_i = W'($urandom_range(1, 255));
      end
      step();
      start_i = 1'b0;
      if (rdy) idx++;
      cyc++;
      if (cyc > 4000) begin
        chk("burst_timeout", 1, 0);
        return;
      end
    end
    out_ready_i = 1'b0;
    chk("end_done", done_o, 1);
    chk("end_valid", out_valid_o, 0);
    chk("end_busy", busy_o, 1);
    chk("end_wrap", wrap_o, carry_after[count]);
    step();
    chk("idle_done", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", out_valid_o, 0);
    chk("idle_wrap", wrap_o, carry_after[count]);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    base_i = '0;
    count_i = '0;
    out_ready_i = 1'b0;
    step();
    step();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wrap", wrap_o, 0);
    rst = 1'b0;
    step();

    // Basic burst, backpressure, wrap, empty burst.
    run_burst('h10, 4, 0, 1'b0);
    run_burst('h10, 4, 2, 1'b0);
    run_burst('hFD, 3, 0, 1'b0);
    run_burst(0, 0, 0, 1'b0);

    // Empty burst right after a wrapping burst must clear wrap.
    run_burst('hFE, 2, 0, 1'b0);
    run_burst('h33, 0, 0, 1'b0);

    // Reset during the second beat.
    start_i = 1'b1;
    base_i  = 8'h20;
    count_i = 8'd5;
    out_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("mid_beat0", addr_o, 'h20);
    step();
    chk("mid_beat1", addr_o, 'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready_i = 1'b0;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_addr", addr_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_wrap", wrap_o, 0);
    step();
    chk("mid_rst_no_done", done_o, 0);
    run_burst('h40, 3, 0, 1'b0);

    // Start while busy is ignored.
    run_burst('h80, 6, 1, 1'b1);

    // Random bursts with random backpressure and stray starts.
    for (int n = 0; n < 12; n++) begin
      run_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                1, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addr_step_gen.md
# addr_step_gen

Sequential address/operand generator that drives the team's 8-bit constant-step adder stage. It produces a burst of `count_i` values starting at `base_i` and advancing by `STEP` per accepted output, wrapping modulo 2^WIDTH. Results go to the downstream consumer over a valid/ready handshake. The block owns the register, count and handshake logic around a purely combinational step-add sub-module.

## Interface

**Parameters**
- `WIDTH`, default 8: address/operand width; count width is also `WIDTH`.
- `STEP`, default 2: constant added per accepted beat; must be < 2^WIDTH.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: request a new burst; sampled only in IDLE.
- `base_i`, in, WIDTH: first value of the burst; captured with `start_i`.
- `count_i`, in, WIDTH: number of beats; captured with `start_i`; 0 means an empty burst.
- `out_valid_o`, out, 1: `addr_o` holds a valid beat.
- `out_ready_i`, in, 1: consumer accepts the beat.
- `addr_o`, out, WIDTH: current value (registered).
- `busy_o`, out, 1: high in RUN and DONE.
- `done_o`, out, 1: one-cycle pulse at the end of a burst.
- `wrap_o`, out, 1: sticky flag, set if any step produced a carry-out; cleared on accepted start.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start_i`=1 with `count_i`≠0: `addr`←`base_i`, `remaining`←`count_i`, `wrap_o`←0, go to RUN.
  - `start_i`=1 with `count_i`=0: `wrap_o`←0, go to DONE; no beat is emitted.
- **RUN:**
  - `out_valid_o`=1.
  - A beat is accepted when `out_valid_o` && `out_ready_i`.
  - On accept: `addr`←(`addr`+STEP) mod 2^WIDTH and `remaining`←`remaining`−1.
  - If the add carries out, `wrap_o`←1.
  - If `remaining`==1 at the accept, go to DONE. `addr` still advances, but it is no longer valid.
  - With no accept, `addr_o`, `out_valid_o` and `remaining` hold. Standard valid/ready rule: `addr_o` is stable while valid is high and ready is low.
- **DONE:** `done_o`=1 for exactly one cycle, then go to IDLE.
- `start_i` outside IDLE is ignored and not queued.
- Arithmetic: the add is unsigned and modulo 2^WIDTH. Carry-out is the bit-WIDTH result of the step adder. With an even STEP, `addr_o[0]` equals `base_i[0]` for the whole burst.

## Timing
- **Reset values:** state=IDLE, `out_valid_o`=0, `addr_o`=0, `busy_o`=0, `done_o`=0, `wrap_o`=0, `remaining`=0.
- **Reset mid-burst:** on the next edge everything returns to reset values. The pending beat is dropped and no `done_o` pulse is generated.
- **Start to first beat:** `out_valid_o` rises the cycle after `start_i` is sampled in IDLE.
- **Throughput:** 1 beat/cycle with `out_ready_i` held high.
- **Burst end:** `done_o` asserts the cycle after the last accept and `busy_o` falls one cycle later. The earliest next start is sampled in the cycle after DONE.
- **Empty burst:** `done_o` asserts the cycle after start.
- **Registered outputs:** all outputs come from registers; there is no combinational path from `out_ready_i` to `out_valid_o`.

## Structure
- **Shared package `addr_step_pkg`:**
  - state enum (IDLE/RUN/DONE);
  - `WIDTH`/`STEP` defaults;
  - `addr_t` typedef.
- **Sub-module `step_add`:** combinational, `WIDTH`-bit input, constant `STEP`, outputs the `WIDTH`-bit sum and the carry. It is instantiated once; all registers stay in `addr_step_gen`.

## Test plan
1. **Basic burst:** `base_i`=0x10, `count_i`=4, ready=1 → `addr_o` 0x10, 0x12, 0x14, 0x16 on 4 consecutive cycles; `done_o` pulses the next cycle; `wrap_o`=0.
2. **Backpressure:** same burst with ready low for 3 cycles during beat 0x12 → `addr_o` holds 0x12 with valid=1 throughout; no beat is lost or duplicated.
3. **Wrap:** `base_i`=0xFD, `count_i`=3 → 0xFD, 0xFF, 0x01; `wrap_o`=1 from the cycle after the 0xFF accept; `addr_o[0]`=1 throughout.
4. **Empty burst:** `count_i`=0 → `done_o` pulses the cycle after start; `out_valid_o` never rises.
5. **Reset mid-burst:** `rst` during the 2nd beat → the next cycle has all outputs 0 and state IDLE; a new start works normally.
6. **Start while busy:** `start_i` with a new base during RUN → ignored; the original sequence completes unchanged.
